// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: command scheduler in front of the motor PWM controller.
// Accepts signed 11-bit left/right target speeds over a valid/ready handshake
// and slews the lft/rht commands toward them by at most STEP counts per PWM
// period (2**PERIOD_BITS clocks). Emergency stop zeroes both commands at once.
//
// Optional feature: define MOTOR_WDOG_EN to add a command watchdog. If no
// command is accepted for WD_PERIODS periods, both targets fall to zero and
// the outputs ramp down normally.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous reset, active-high
//   cmd_vld  new target pair valid
//   cmd_rdy  scheduler can accept a target pair (combinational)
//   cmd_lft  signed left target speed
//   cmd_rht  signed right target speed
//   estop    emergency stop, level-sensitive
//   lft      signed left command to the PWM controller
//   rht      signed right command to the PWM controller
//   busy     1 while either output differs from its target
//   tick     1-cycle strobe in the last clock of each period
module motor_ramp_sched #(
    parameter int unsigned PERIOD_BITS = 10,
    parameter int unsigned STEP        = 32,
    parameter int unsigned WD_PERIODS  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] cmd_lft,
    input  logic [10:0] cmd_rht,
    input  logic        estop,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        busy,
    output logic        tick
);

    localparam int unsigned DW = 11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RAMP  = 2'd1;
    localparam logic [1:0] S_ESTOP = 2'd2;

    localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;
    localparam logic signed [DW:0]     STEP_S  = (DW+1)'(STEP);
    localparam logic [DW-1:0]          STEP_U  = DW'(STEP);
    localparam logic [DW-1:0]          NEG_MAX = 11'h400;   // -1024
    localparam logic [DW-1:0]          NEG_LIM = 11'h401;   // -1023

    // Reject parameter values the datapath cannot represent.
    if (STEP < 1 || STEP > 1023 || WD_PERIODS < 1) begin : g_bad_param
        $error("motor_ramp_sched: STEP must be 1..1023 and WD_PERIODS >= 1");
    end

    logic [1:0]             state_q, state_d;
    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic [DW-1:0]          lft_q, lft_d, rht_q, rht_d;
    logic [DW-1:0]          tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic                   busy_q, busy_d;
    logic                   accept_c;

`ifdef MOTOR_WDOG_EN
    localparam int unsigned          WD_W   = $clog2(WD_PERIODS + 1);
    localparam logic [WD_W-1:0]      WD_LIM = WD_W'(WD_PERIODS);
    logic [WD_W-1:0]                 wd_q, wd_d;
`endif

    // -1024 has no positive counterpart; pull it in to keep the range symmetric.
    function automatic logic [DW-1:0] clamp_tgt(input logic [DW-1:0] v);
        return (v == NEG_MAX) ? NEG_LIM : v;
    endfunction

    // Move cur toward tgt by at most STEP; difference taken at 12 bits so it cannot wrap.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt);
        logic signed [DW:0] diff;
        diff = $signed({tgt[DW-1], tgt}) - $signed({cur[DW-1], cur});
        if (diff > STEP_S) begin
            return cur + STEP_U;
        end else if (diff < -STEP_S) begin
            return cur - STEP_U;
        end else begin
            return tgt;
        end
    endfunction

    assign cmd_rdy  = !rst && (state_q != S_ESTOP);
    assign accept_c = cmd_vld && cmd_rdy;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tick_q  <= tick_d;
        lft_q   <= lft_d;
        rht_q   <= rht_d;
        tgt_l_q <= tgt_l_d;
        tgt_r_q <= tgt_r_d;
        busy_q  <= busy_d;
`ifdef MOTOR_WDOG_EN
        wd_q    <= wd_d;
`endif
    end

    // Next-state: rst > estop > (step, accept).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + PERIOD_BITS'(1);
        tick_d  = 1'b0;
        lft_d   = lft_q;
        rht_d   = rht_q;
        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        busy_d  = busy_q;
`ifdef MOTOR_WDOG_EN
        wd_d    = wd_q;
`endif

        tick_d = (cnt_d == CNT_MAX);

        if (rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tick_d  = 1'b0;
            lft_d   = '0;
            rht_d   = '0;
            tgt_l_d = '0;
            tgt_r_d = '0;
            busy_d  = 1'b0;
`ifdef MOTOR_WDOG_EN
            wd_d    = '0;
`endif
        end else if (estop) begin
            state_d = S_ESTOP;
            lft_d   = '0;
            rht_d   = '0;
            tgt_l_d = '0;
            tgt_r_d = '0;
            busy_d  = 1'b0;
`ifdef MOTOR_WDOG_EN
            wd_d    = '0;
`endif
        end else if (state_q == S_ESTOP) begin
            // Outputs and targets are already zero; leave only on a period boundary.
            if (tick_q) begin
                state_d = S_IDLE;
            end
        end else begin
            // Step uses the targets held before this edge; a coincident accept
            // only takes effect from the next tick.
            if (tick_q) begin
                lft_d = step_toward(lft_q, tgt_l_q);
                rht_d = step_toward(rht_q, tgt_r_q);
            end
            if (accept_c) begin
                tgt_l_d = clamp_tgt(cmd_lft);
                tgt_r_d = clamp_tgt(cmd_rht);
            end
`ifdef MOTOR_WDOG_EN
            // Counts periods since the last accept, saturating at the limit.
            if (accept_c) begin
                wd_d = '0;
            end else if (tick_q && (wd_q != WD_LIM)) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (!accept_c && (wd_q != WD_LIM) && (wd_d == WD_LIM)) begin
                tgt_l_d = '0;
                tgt_r_d = '0;
            end
`endif
            busy_d  = (lft_d != tgt_l_d) || (rht_d != tgt_r_d);
            state_d = busy_d ? S_RAMP : S_IDLE;
        end
    end

    assign lft  = lft_q;
    assign rht  = rht_q;
    assign busy = busy_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_motor_ramp_sched.sv
// Bench for motor_ramp_sched (STEP=32, PERIOD_BITS=10, WD_PERIODS=4).
module tb_motor_ramp_sched;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_vld;
    logic               cmd_rdy;
    logic [10:0]        cmd_lft;
    logic [10:0]        cmd_rht;
    logic               estop;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               busy;
    logic               tick;

    always #5 clk = ~clk;

    motor_ramp_sched #(
        .PERIOD_BITS(10),
        .STEP       (32),
        .WD_PERIODS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd_vld(cmd_vld),
        .cmd_rdy(cmd_rdy),
        .cmd_lft(cmd_lft),
        .cmd_rht(cmd_rht),
        .estop  (estop),
        .lft    (lft),
        .rht    (rht),
        .busy   (busy),
        .tick   (tick)
    );

    typedef struct {
        string              name;
        logic signed [10:0] l;
        logic signed [10:0] r;
        logic               b;
    } exp_t;

    typedef struct {
        bit                 do_rst;
        bit                 acc;
        logic signed [10:0] cl;
        logic signed [10:0] cr;
        logic signed [10:0] el;
        logic signed [10:0] er;
        logic               eb;
    } vec_t;

    exp_t sb[$];
    vec_t vt[15];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk_s(input string name, input logic signed [10:0] act,
                         input logic signed [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic signed [10:0] l,
                           input logic signed [10:0] r, input logic b);
        exp_t e;
        e.name = name; e.l = l; e.r = r; e.b = b;
        sb.push_back(e);
    endtask

    // Compare the DUT's post-tick outputs against the oldest expectation.
    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue, want an entry");
            return;
        end
        e = sb.pop_front();
        chk_s({e.name, ".lft"},  lft,  e.l);
        chk_s({e.name, ".rht"},  rht,  e.r);
        chk_b({e.name, ".busy"}, busy, e.b);
    endtask

    // From a negedge, advance to the negedge where tick is high (bounded).
    task automatic find_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL tick_timeout: got no tick in %0d cycles, want one", n);
        end
    endtask

    // Advance past the next tick edge, sampling one half-cycle after the step.
    task automatic wait_tick();
        find_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0;
        #1 chk_b("rst.cmd_rdy", cmd_rdy, 1'b0);
        @(negedge clk);
        chk_s("rst.lft", lft, 11'sd0);
        chk_s("rst.rht", rht, 11'sd0);
        chk_b("rst.busy", busy, 1'b0);
        chk_b("rst.tick", tick, 1'b0);
        rst = 1'b0;
    endtask

    // One-cycle transfer starting at a negedge.
    task automatic accept(input logic [10:0] l, input logic [10:0] r);
        cmd_vld = 1'b1; cmd_lft = l; cmd_rht = r;
        #1 chk_b("acc.cmd_rdy", cmd_rdy, 1'b1);
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0; cmd_lft = '0; cmd_rht = '0;

        // Basic ramp to (+100,-100), then a mid-ramp retarget from +64 toward -200.
        vt[0]  = '{1, 1,  11'sd100, -11'sd100,  11'sd32,  -11'sd32, 1};
        vt[1]  = '{0, 0,  11'sd0,    11'sd0,    11'sd64,  -11'sd64, 1};
        vt[2]  = '{0, 0,  11'sd0,    11'sd0,    11'sd96,  -11'sd96, 1};
        vt[3]  = '{0, 0,  11'sd0,    11'sd0,    11'sd100, -11'sd100, 0};
        vt[4]  = '{1, 1,  11'sd500,  11'sd0,    11'sd32,   11'sd0,  1};
        vt[5]  = '{0, 0,  11'sd0,    11'sd0,    11'sd64,   11'sd0,  1};
        vt[6]  = '{0, 1, -11'sd200,  11'sd0,    11'sd32,   11'sd0,  1};
        vt[7]  = '{0, 0,  11'sd0,    11'sd0,    11'sd0,    11'sd0,  1};
        vt[8]  = '{0, 0,  11'sd0,    11'sd0,   -11'sd32,   11'sd0,  1};
        vt[9]  = '{0, 0,  11'sd0,    11'sd0,   -11'sd64,   11'sd0,  1};
        vt[10] = '{0, 0,  11'sd0,    11'sd0,   -11'sd96,   11'sd0,  1};
        vt[11] = '{0, 0,  11'sd0,    11'sd0,   -11'sd128,  11'sd0,  1};
        vt[12] = '{0, 0,  11'sd0,    11'sd0,   -11'sd160,  11'sd0,  1};
        vt[13] = '{0, 0,  11'sd0,    11'sd0,   -11'sd192,  11'sd0,  1};
        vt[14] = '{0, 0,  11'sd0,    11'sd0,   -11'sd200,  11'sd0,  0};

        for (int i = 0; i < 15; i++) begin
            if (vt[i].do_rst) do_reset();
            if (vt[i].acc) accept(vt[i].cl, vt[i].cr);
            sb_push($sformatf("vec%0d", i), vt[i].el, vt[i].er, vt[i].eb);
            if (i == 0) begin
                // Outputs hold between ticks.
                repeat (500) @(negedge clk);
                chk_s("hold.lft", lft, 11'sd0);
                chk_b("hold.busy", busy, 1'b1);
            end
            wait_tick();
            sb_check();
        end

        // -1024 target is loaded as -1023; full-scale ramp both ways.
        do_reset();
        accept(11'h400, 11'd1023);
        chk_b("fs.busy0", busy, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            int el, er;
            el = (32 * k > 1023) ? -1023 : -32 * k;
            er = (32 * k > 1023) ?  1023 :  32 * k;
            sb_push($sformatf("fs%0d", k), 11'(el), 11'(er), k < 32);
            wait_tick();
            sb_check();
        end

        // Emergency stop mid-ramp, commands ignored while stopped.
        do_reset();
        accept(11'd500, 11'd500);
        wait_tick();
        wait_tick();
        chk_s("es.pre_lft", lft, 11'sd64);
        estop = 1'b1; cmd_vld = 1'b1; cmd_lft = 11'd200; cmd_rht = 11'd200;
        @(negedge clk);
        chk_s("es.lft", lft, 11'sd0);
        chk_s("es.rht", rht, 11'sd0);
        chk_b("es.busy", busy, 1'b0);
        chk_b("es.cmd_rdy", cmd_rdy, 1'b0);
        repeat (20) @(negedge clk);
        chk_b("es.busy_hold", busy, 1'b0);
        chk_s("es.lft_hold", lft, 11'sd0);
        cmd_vld = 1'b0; estop = 1'b0;
        @(negedge clk);
        chk_b("es.rdy_until_tick", cmd_rdy, 1'b0);
        wait_tick();
        chk_b("es.rdy_after_tick", cmd_rdy, 1'b1);
        chk_s("es.lft_after", lft, 11'sd0);
        chk_b("es.busy_after", busy, 1'b0);

        // Accept coincident with a tick: that step uses the old (zero) targets.
        do_reset();
        find_tick();
        accept(11'd64, 11'd0);
        chk_s("coinc.lft", lft, 11'sd0);
        chk_b("coinc.busy", busy, 1'b1);
        sb_push("coinc1", 11'sd32, 11'sd0, 1'b1);
        wait_tick();
        sb_check();
        sb_push("coinc2", 11'sd64, 11'sd0, 1'b0);
        wait_tick();
        sb_check();
        begin
            // Tick spacing is one full period and the strobe lasts one clock.
            int n = 0;
            while (tick !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            n_vec++;
            if (n != 1023) begin
                n_err++;
                $display("FAIL tick_period: got %0d, want 1023", n);
            end
            @(negedge clk);
            chk_b("tick_width", tick, 1'b0);
        end

        // Watchdog: settle at 100 with no further commands.
        do_reset();
        accept(11'd100, 11'd0);
        for (int k = 1; k <= 8; k++) begin
            int el;
            logic eb;
            if (k <= 3) begin
                el = 32 * k; eb = 1'b1;
            end else if (k == 4) begin
`ifdef MOTOR_WDOG_EN
                el = 100; eb = 1'b1;
`else
                el = 100; eb = 1'b0;
`endif
            end else begin
`ifdef MOTOR_WDOG_EN
                el = (100 - 32 * (k - 4) < 0) ? 0 : 100 - 32 * (k - 4);
                eb = (el != 0);
`else
                el = 100; eb = 1'b0;
`endif
            end
            sb_push($sformatf("wd%0d", k), 11'(el), 11'sd0, eb);
            wait_tick();
            sb_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
